// File: rtl/demux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : demux_scheduler
// Purpose  : Round-robin burst scheduler steering a serial bit stream to one
//            of eight destination channels through a 3-stage demux tree.
// Revision : 1.0 - initial release
// ============================================================================
module demux_scheduler #(
   parameter int BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       D,
   input  logic       valid,
   input  logic [7:0] ready,
   output logic       accept,
   output logic [7:0] y,
   output logic [7:0] stb,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic [2:0] ch,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] ch_q, ch_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] y_q, y_d;
   logic [7:0] stb_q, stb_d;
   logic       busy_q, busy_d;

   logic       found;
   logic [2:0] pick;
   logic [2:0] idx;

   assign accept = !rst && (state_q == XFER) && valid && ready[ch_q];

   // Search begins one past the last granted channel; i=8 wraps back to ptr itself.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = ptr_q;
      for (int i = 1; i <= 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!found && ready[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      y_d     = 8'h00;
      stb_d   = 8'h00;

      case (state_q)
         IDLE: begin
            if (valid) state_d = ARB;
         end
         ARB: begin
            if (!valid) begin
               state_d = IDLE;
            end else if (found) begin
               ch_d    = pick;
               cnt_d   = 4'd0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (accept) begin
               cnt_d       = cnt_q + 4'd1;
               y_d[ch_q]   = D;
               stb_d[ch_q] = 1'b1;
            end
            if ((accept && (cnt_q == LAST_CNT)) || !valid || !ready[ch_q]) begin
               ptr_d   = ch_q;
               state_d = valid ? ARB : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Demux legs select the lower index on 1, hence the inversion.
      sel_d  = ~ch_d;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 3'd7;
         cnt_q   <= 4'd0;
         ch_q    <= 3'd0;
         sel_q   <= 3'b111;
         y_q     <= 8'h00;
         stb_q   <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         sel_q   <= sel_d;
         y_q     <= y_d;
         stb_q   <= stb_d;
         busy_q  <= busy_d;
      end
   end

   assign y            = y_q;
   assign stb          = stb_q;
   assign ch           = ch_q;
   assign busy         = busy_q;
   assign {s0, s1, s2} = sel_q;

endmodule
`default_nettype wire

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter: BURST, default 4, maximum number of bits delivered to one channel before the grant rotates (legal range 1..16).
REQ-002 clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 D  input  1  serial data bit offered by the source.
REQ-005 valid  input  1  source has a bit on D.
REQ-006 ready  input  8  ready[k]=1: destination channel k can take a bit this cycle.
REQ-007 accept  output  1  combinational; the bit on D is consumed this cycle.
REQ-008 y  output  8  registered demux data outputs, one per channel.
REQ-009 stb  output  8  registered per-channel strobe marking a delivered bit.
REQ-010 s0, s1, s2  output  1 each  registered demux select lines for the current channel.
REQ-011 ch  output  3  registered index of the currently granted channel.
REQ-012 busy  output  1  registered; high while state is ARB or XFER.

Function
REQ-013 The FSM SHALL have three states: IDLE, ARB and XFER.
REQ-014 IDLE: accept=0; valid=1 -> ARB next cycle; otherwise stay in IDLE.
REQ-015 ARB: accept=0; search ready round-robin, starting at (ptr+1) mod 8 and wrapping 7->0.
- First ready channel found: ch <= that index, cnt <= 0, state -> XFER.
- No channel ready and valid=1: stay in ARB.
- valid=0: go to IDLE.
REQ-016 XFER: accept = valid & ready[ch], with no other term.
REQ-017 Each accepted cycle SHALL increment the 4-bit counter cnt.
REQ-018 XFER exit: leave XFER when any of the following holds in a cycle.
- accept=1 and cnt==BURST-1.
- valid=0.
- ready[ch]=0.
On exit: ptr <= ch; next state is ARB if valid=1, else IDLE.
REQ-019 Delivery latency SHALL be 1 cycle: the cycle after an accept, y[ch]=D and stb[ch]=1, and all other y and stb bits are 0.
REQ-020 In every cycle after a non-accept cycle, y SHALL be 8'h00 and stb SHALL be 8'h00.
REQ-021 At most one bit of stb SHALL be high in any cycle.
REQ-022 Select encoding SHALL follow the team's demux polarity, where a select of 1 routes to the lower-index leg.
- {s0,s1,s2} = ~ch; s0 is the first tree stage.
- ch=0 -> s0,s1,s2 = 1,1,1; ch=7 -> 0,0,0.
REQ-023 s0..s2 SHALL update in the same cycle that ch updates.
REQ-024 With BURST=1, the grant SHALL rotate after every delivered bit.
REQ-025 A single ready channel SHALL be re-granted through ARB after each burst, costing one idle (ARB) cycle between bursts.
REQ-026 A ready change during ARB SHALL affect only the ARB search in that same cycle.

Reset
REQ-027 While rst=1, the next-state values SHALL be:
- state=IDLE, ptr=7 (so the first search starts at channel 0), cnt=0.
- ch=0, s0=s1=s2=1, y=8'h00, stb=8'h00, busy=0.
REQ-028 While rst=1, accept SHALL be 0.
REQ-029 Reset asserted during XFER SHALL discard the burst; no stb SHALL appear in the cycle after reset.
REQ-030 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-031 Reset then idle: rst=1 for 2 cycles, then valid=0 -> y=0, stb=0, busy=0, s0..s2=111, accept=0 throughout.
REQ-032 Full burst: ready=8'hFF, valid held, D=1,0,1,1,1 ->
- ch=0; stb[0] pulses 4 times with y[0]=1,0,1,1.
- 1 ARB cycle follows; then ch=1, s0..s2=110, and the fifth bit appears on y[1].
REQ-033 Round-robin wrap: ready=8'h81, valid held, BURST=4 -> grant order 0,7,0,7; at ch=7, s0..s2=000.
REQ-034 Mid-burst ready drop: ready[2] falls after 2 accepts (only channel 2 ready) ->
- accept drops in the same cycle; exactly 2 stb[2] pulses.
- FSM holds in ARB until ready[2] returns, then a new burst of up to 4 begins.
REQ-035 Reset mid-operation: rst asserted during the 3rd accept cycle of XFER -> next cycle stb=0, state IDLE; the next grant is channel 0.
REQ-036 Source stall: valid=0 after 1 accept -> IDLE; on return of valid, the search starts after the last granted channel.
